// File: rtl/com_uart.sv
// com_uart: 8N1 UART endpoint with single-byte receive holding register and COM_STAT flags.
module com_uart #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       enable_write,
  output logic       write_ready,
  output logic [7:0] data_out,
  output logic       read_ready,
  input  logic       read_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic       rxd,
  output logic       txd
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_e;
  tx_e tx_q, tx_d;
  rx_e rx_q, rx_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, dout_q, dout_d;
  logic rdy_q, rdy_d, ovr_q, ovr_d, ferr_q, ferr_d, sync1_q, rxd_s;
  logic tx_tick, rx_tick, done, ferr;
  always_ff @(posedge clk50M) begin
    if (rst) begin
      tx_q <= TX_IDLE;
      rx_q <= RX_IDLE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_bit_q <= '0;
      rx_bit_q <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      dout_q <= '0;
      rdy_q <= 1'b0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
      sync1_q <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_bit_q <= tx_bit_d;
      rx_bit_q <= rx_bit_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      dout_q <= dout_d;
      rdy_q <= rdy_d;
      ovr_q <= ovr_d;
      ferr_q <= ferr_d;
      sync1_q <= rxd;
      rxd_s <= sync1_q;
    end
  end
  always_comb begin
    tx_d = tx_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_tick = tx_cnt_q == LAST;
    tx_cnt_d = (tx_q == TX_IDLE || tx_tick) ? '0 : tx_cnt_q + 1'b1;
    case (tx_q)
      TX_IDLE: if (enable_write) begin
        tx_d = TX_START;
        tx_sh_d = data_in;
        tx_bit_d = '0;
      end
      TX_START: tx_d = tx_tick ? TX_DATA : TX_START;
      TX_DATA: if (tx_tick) begin
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 1'b1;
        tx_d = (tx_bit_q == 3'd7) ? TX_STOP : TX_DATA;
      end
      default: tx_d = tx_tick ? TX_IDLE : TX_STOP;
    endcase
  end
  always_comb begin
    rx_d = rx_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    done = 1'b0;
    ferr = 1'b0;
    rx_tick = rx_cnt_q == ((rx_q == RX_START) ? HALF : LAST);
    rx_cnt_d = (rx_q == RX_IDLE || rx_q == RX_WAIT_HIGH || rx_tick) ? '0 : rx_cnt_q + 1'b1;
    case (rx_q)
      RX_IDLE: rx_d = rxd_s ? RX_IDLE : RX_START;
      RX_START: if (rx_tick) begin
        rx_d = rxd_s ? RX_IDLE : RX_DATA;
        rx_bit_d = '0;
      end
      RX_DATA: if (rx_tick) begin
        rx_sh_d = {rxd_s, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        rx_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (rx_tick) begin
        done = rxd_s;
        ferr = ~rxd_s;
        rx_d = rxd_s ? RX_IDLE : RX_WAIT_HIGH;
      end
      default: rx_d = rxd_s ? RX_IDLE : RX_WAIT_HIGH;
    endcase
    dout_d = done ? rx_sh_q : dout_q;
    rdy_d = done | (rdy_q & ~read_ack);
    ovr_d = done & rdy_q & ~read_ack;
    ferr_d = ferr;
  end
  assign txd = (tx_q == TX_START) ? 1'b0 : (tx_q == TX_DATA) ? tx_sh_q[0] : 1'b1;
  assign write_ready = tx_q == TX_IDLE;
  assign data_out = dout_q;
  assign read_ready = rdy_q;
  assign rx_overrun = ovr_q;
  assign rx_frame_err = ferr_q;
endmodule

// File: tb/tb_com_uart.sv
// tb_com_uart: directed plus randomized checks of com_uart against a frame-level reference model.
module tb_com_uart;
  localparam int C = 16;
  logic clk50M = 1'b0, rst = 1'b1, enable_write = 1'b0, read_ack = 1'b0, rxd = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic write_ready, read_ready, rx_overrun, rx_frame_err, txd;
  logic [7:0] data_out;
  int vectors = 0, errs = 0, n_ovr = 0, n_ferr = 0, exp_ovr = 0, exp_ferr = 0;
  logic [7:0] exp_dout = 8'h00;
  logic exp_rdy = 1'b0;
  com_uart #(.CLKS_PER_BIT(C)) dut (
    .clk50M(clk50M), .rst(rst), .data_in(data_in), .enable_write(enable_write),
    .write_ready(write_ready), .data_out(data_out), .read_ready(read_ready),
    .read_ack(read_ack), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
    .rxd(rxd), .txd(txd)
  );
  always #5 clk50M = ~clk50M;
  always @(negedge clk50M) begin
    if (rx_overrun) n_ovr++;
    if (rx_frame_err) n_ferr++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk50M);
  endtask
  task automatic tx_frame(input logic [7:0] b, input bit intrude);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    data_in = b;
    enable_write = 1'b1;
    cyc(1);
    enable_write = 1'b0;
    cyc(8);
    for (int k = 0; k < 10; k++) begin
      chk("txd_bit", txd, f[k]);
      chk("tx_busy", write_ready, 0);
      if (k < 9) begin
        if (intrude && k == 2) begin
          data_in = 8'h3C;
          enable_write = 1'b1;
          cyc(1);
          enable_write = 1'b0;
          cyc(15);
        end else cyc(16);
      end
    end
    cyc(7);
    chk("tx_busy_last", write_ready, 0);
    cyc(1);
    chk("tx_ready_again", write_ready, 1);
    chk("tx_idle_high", txd, 1);
  endtask
  task automatic rx_send(input logic [7:0] b, input bit stop, input bit ack_done, input int tail_low);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int c = 0; c < 10 * C; c++) begin
      rxd = f[c / C];
      read_ack = ack_done && c == 154;
      cyc(1);
    end
    read_ack = 1'b0;
    if (tail_low > 0) begin
      rxd = 1'b0;
      cyc(tail_low);
    end
    rxd = 1'b1;
    cyc(4);
  endtask
  task automatic model_byte(input logic [7:0] b, input bit ack_same);
    if (exp_rdy && !ack_same) exp_ovr++;
    exp_dout = b;
    exp_rdy = 1'b1;
  endtask
  task automatic chk_rx(input string tag);
    chk({tag, "_data"}, data_out, exp_dout);
    chk({tag, "_ready"}, read_ready, exp_rdy);
    chk({tag, "_overruns"}, n_ovr, exp_ovr);
    chk({tag, "_frame_errs"}, n_ferr, exp_ferr);
  endtask
  initial begin
    logic [7:0] b;
    logic [9:0] f;
    bit low;
    int mode;
    cyc(3);
    chk("rst_txd", txd, 1);
    chk("rst_write_ready", write_ready, 1);
    chk("rst_read_ready", read_ready, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_frame_err", rx_frame_err, 0);
    rst = 1'b0;
    cyc(2);
    tx_frame(8'hA5, 1'b1);
    low = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!txd) low = 1'b1;
      cyc(1);
    end
    chk("tx_no_second_frame", low, 0);
    tx_frame(8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) tx_frame(8'($urandom), 1'b0);
    rx_send(8'h5A, 1'b1, 1'b0, 0);
    model_byte(8'h5A, 1'b0);
    chk_rx("rx_5a");
    read_ack = 1'b1;
    cyc(1);
    read_ack = 1'b0;
    exp_rdy = 1'b0;
    chk("ack_clears_ready", read_ready, 0);
    rx_send(8'hFF, 1'b0, 1'b0, 200);
    exp_ferr++;
    chk_rx("rx_frame_err");
    rxd = 1'b0;
    cyc(4);
    rxd = 1'b1;
    cyc(200);
    chk_rx("rx_glitch");
    rx_send(8'h11, 1'b1, 1'b0, 0);
    model_byte(8'h11, 1'b0);
    rx_send(8'h22, 1'b1, 1'b0, 0);
    model_byte(8'h22, 1'b0);
    chk_rx("rx_overrun");
    rx_send(8'h33, 1'b1, 1'b1, 0);
    model_byte(8'h33, 1'b1);
    chk_rx("rx_ack_coincident");
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      mode = int'($urandom_range(0, 2));
      if (mode == 1) begin
        read_ack = 1'b1;
        cyc(3);
        read_ack = 1'b0;
        cyc(1);
        exp_rdy = 1'b0;
        chk("rand_ack_held", read_ready, 0);
      end
      rx_send(b, 1'b1, mode == 2, 0);
      model_byte(b, mode == 2);
      chk_rx("rx_rand");
    end
    b = {3'b111, 5'($urandom)};
    f = {1'b1, b, 1'b0};
    for (int r = 0; r < 10 * C; r++) begin
      rxd = f[r / C];
      enable_write = r == 36;
      data_in = 8'($urandom) & 8'hF7;
      rst = r == 104;
      cyc(1);
      if (r == 104) begin
        chk("midrst_txd", txd, 1);
        chk("midrst_write_ready", write_ready, 1);
        chk("midrst_read_ready", read_ready, 0);
        chk("midrst_data_out", data_out, 0);
      end
    end
    rst = 1'b0;
    enable_write = 1'b0;
    rxd = 1'b1;
    cyc(200);
    exp_rdy = 1'b0;
    exp_dout = 8'h00;
    chk_rx("post_rst");
    chk("post_rst_txd", txd, 1);
    chk("post_rst_write_ready", write_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
